// File: rtl/aes_pkg.sv
// Shared AES definitions: control state encoding, state geometry and GF(2^8) helpers
// used by the forward and inverse S-box modules.
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_BYTES   = 16;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } aes_state_e;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int unsigned i = 0; i < 8; i++) begin
      r = gf_mul(r, r);
      if (e[7-i]) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    return (v << n) | (v >> (8 - n));
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Inverse AES S-box: inverse affine transform followed by the GF(2^8) inverse.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] t;

  always_comb begin
    t        = rotl8(in_byte, 1) ^ rotl8(in_byte, 3) ^ rotl8(in_byte, 6) ^ 8'h05;
    out_byte = gf_inv(t);
  end

endmodule

// File: rtl/sbox.sv
// Forward AES S-box: GF(2^8) inverse followed by the affine transform.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] b;

  always_comb begin
    b        = gf_inv(in_byte);
    out_byte = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  end

endmodule

// File: rtl/subbytes_seq.sv
// Sequential SubBytes engine: LANES bytes per cycle, result held until taken.
// Optional inverse substitution is enabled with `define SUBBYTES_SEQ_INV_EN.
module subbytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_data,
  input  logic                   inv,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_data
);

  localparam int unsigned CHUNKS = AES_BYTES / LANES;
  localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNKS - 1);

  aes_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] work_q, work_d;
  logic [AES_STATE_W-1:0] out_q, out_d;
  logic                   inv_q, inv_d;

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];

  // Lane l of chunk cnt is byte cnt*LANES+l, counted from the MSB end.
  always_comb begin
    int unsigned base;
    base = int'(cnt_q) * LANES;
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_in[l] = work_q[AES_STATE_W-1-8*(base+l) -: 8];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] fwd;
    sbox u_sbox (.in_byte(lane_in[l]), .out_byte(fwd));
`ifdef SUBBYTES_SEQ_INV_EN
    logic [7:0] rev;
    inv_sbox u_inv_sbox (.in_byte(lane_in[l]), .out_byte(rev));
    assign lane_out[l] = inv_q ? rev : fwd;
`else
    assign lane_out[l] = fwd;
`endif
  end

`ifndef SUBBYTES_SEQ_INV_EN
  logic unused_inv;
  assign unused_inv = inv_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      out_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      out_q   <= out_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    int unsigned base;
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    out_d   = out_q;
    inv_d   = inv_q;
    base    = int'(cnt_q) * LANES;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          inv_d   = inv;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          out_d[AES_STATE_W-1-8*(base+l) -: 8] = lane_out[l];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = out_q;
  end

endmodule

// File: tb/tb_subbytes_seq.sv
// Directed testbench for subbytes_seq with LANES = 4, 1 and 16 instances side by side.
module tb_subbytes_seq;

  localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] ALL_FF   = {16{8'hff}};
  localparam logic [127:0] ALL_16   = {16{8'h16}};

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic         inv;
  logic [2:0]   in_valid_v;
  logic [2:0]   out_ready_v;
  logic [2:0]   in_ready_v;
  logic [2:0]   out_valid_v;
  logic [127:0] out_data_a [3];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  subbytes_seq #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data), .inv(inv), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .out_data(out_data_a[0])
  );

  subbytes_seq #(.LANES(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data), .inv(inv), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .out_data(out_data_a[1])
  );

  subbytes_seq #(.LANES(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data), .inv(inv), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .out_data(out_data_a[2])
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one state to instance i, wait for out_valid, check latency and result.
  task automatic xfer(input int i, input logic [127:0] d, input logic iv,
                      input logic [127:0] exp, input int lat, input string tag,
                      input bit release_out);
    int n;
    @(negedge clk);
    in_data        = d;
    inv            = iv;
    in_valid_v[i]  = 1'b1;
    out_ready_v[i] = 1'b0;
    n = 0;
    while (!in_ready_v[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready"}, 128'(in_ready_v[i]), 128'(1));
    @(negedge clk);
    in_valid_v[i] = 1'b0;
    n = 0;
    while (!out_valid_v[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 128'(n), 128'(lat));
    check({tag, " data"}, out_data_a[i], exp);
    if (release_out) begin
      out_ready_v[i] = 1'b1;
      @(negedge clk);
      check({tag, " release in_ready"}, 128'(in_ready_v[i]), 128'(1));
      check({tag, " release out_valid"}, 128'(out_valid_v[i]), 128'(0));
      out_ready_v[i] = 1'b0;
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_data     = '0;
    inv         = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst in_ready %0d", i), 128'(in_ready_v[i]), 128'(1));
      check($sformatf("rst out_valid %0d", i), 128'(out_valid_v[i]), 128'(0));
      check($sformatf("rst out_data %0d", i), out_data_a[i], '0);
    end
    rst         = 1'b0;
    out_ready_v = '1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("idle in_ready %0d", i), 128'(in_ready_v[i]), 128'(1));
      check($sformatf("idle out_valid %0d", i), 128'(out_valid_v[i]), 128'(0));
      check($sformatf("idle out_data %0d", i), out_data_a[i], '0);
    end
    out_ready_v = '0;

    xfer(0, FIPS_IN, 1'b0, FIPS_OUT, 4, "fips4", 1'b0);

    // Backpressure with a competing input offered.
    in_data       = ALL_FF;
    in_valid_v[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp out_valid", 128'(out_valid_v[0]), 128'(1));
      check("bp out_data", out_data_a[0], FIPS_OUT);
      check("bp in_ready", 128'(in_ready_v[0]), 128'(0));
    end
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    check("bp release in_ready", 128'(in_ready_v[0]), 128'(1));
    check("bp release out_valid", 128'(out_valid_v[0]), 128'(0));
    out_ready_v[0] = 1'b0;

    // Reset in the second BUSY cycle.
    in_data       = FIPS_IN;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst in_ready", 128'(in_ready_v[0]), 128'(1));
    check("midrst out_valid", 128'(out_valid_v[0]), 128'(0));
    check("midrst out_data", out_data_a[0], '0);

    xfer(0, ALL_FF, 1'b0, ALL_16, 4, "ff4", 1'b1);
    xfer(1, FIPS_IN, 1'b0, FIPS_OUT, 16, "fips1", 1'b1);
    xfer(2, FIPS_IN, 1'b0, FIPS_OUT, 1, "fips16", 1'b1);
`ifdef SUBBYTES_SEQ_INV_EN
    xfer(0, FIPS_OUT, 1'b1, FIPS_IN, 4, "inv4", 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
